// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC operand loader.
package mac_pkg;

  localparam int unsigned MAC_WIDTH  = 8;
  localparam int unsigned PAIR_CNT_W = 8;

  // Loader FSM states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/mac_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector.
// The detector keeps tracking its input regardless of any enable, so a
// level that is already high never produces a late event.
module mac_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the asynchronous level into the clock domain and remember the last synced value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign pulse = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/mac_operand_loader.sv
// Collects strobed operand bytes into an A/B pair and offers it to the MAC
// over valid/ready; also generates the accumulator clear pulse and status.
module mac_operand_loader
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH       = MAC_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  strobe_async,
  input  logic                  clear_async,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  acc_clear,
  output logic                  busy,
  output logic                  overrun,
  output logic [PAIR_CNT_W-1:0] pair_count
);

  state_t state;
  logic   strobe_ev;
  logic   clear_ev;
  logic   handshake;

  mac_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (strobe_async),
    .pulse    (strobe_ev)
  );

  mac_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (clear_async),
    .pulse    (clear_ev)
  );

  assign handshake = op_valid & op_ready;
  assign busy      = (state != LOAD_A);

  // Loader FSM and operand/status registers; clear has priority over strobe and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      op_a       <= '0;
      op_b       <= '0;
      op_valid   <= 1'b0;
      acc_clear  <= 1'b0;
      overrun    <= 1'b0;
      pair_count <= '0;
    end else begin
      // acc_clear stays a single-cycle pulse even when ena drops right after a clear.
      acc_clear <= ena & clear_ev;
      if (ena) begin
        if (clear_ev) begin
          state      <= LOAD_A;
          op_valid   <= 1'b0;
          overrun    <= 1'b0;
          pair_count <= '0;
        end else begin
          unique case (state)
            LOAD_A: begin
              if (strobe_ev) begin
                op_a  <= data_in;
                state <= LOAD_B;
              end
            end
            LOAD_B: begin
              if (strobe_ev) begin
                op_b     <= data_in;
                op_valid <= 1'b1;
                state    <= PRESENT;
              end
            end
            PRESENT: begin
              if (handshake) begin
                pair_count <= pair_count + 1'b1;
                op_valid   <= 1'b0;
                if (strobe_ev) begin
                  op_a  <= data_in;
                  state <= LOAD_B;
                end else begin
                  state <= LOAD_A;
                end
              end else if (strobe_ev) begin
                overrun <= 1'b1;
              end
            end
            default: state <= LOAD_A;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Self-checking bench for mac_operand_loader: directed scenarios plus a
// randomized operation sequence checked against a transaction-level model.
module tb_mac_operand_loader;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         strobe_async = 1'b0;
  logic         clear_async = 1'b0;
  logic [W-1:0] op_a, op_b;
  logic         op_valid;
  logic         op_ready = 1'b0;
  logic         acc_clear, busy, overrun;
  logic [7:0]   pair_count;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: bytes collected so far (0, 1 or 2 = pair waiting).
  int       m_have = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic     m_over = 1'b0;
  int       m_pairs = 0;

  mac_operand_loader #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .data_in      (data_in),
    .strobe_async (strobe_async),
    .clear_async  (clear_async),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .acc_clear    (acc_clear),
    .busy         (busy),
    .overrun      (overrun),
    .pair_count   (pair_count)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  task automatic m_strobe(input logic [7:0] d);
    if (m_have == 0) begin m_a = d; m_have = 1; end
    else if (m_have == 1) begin m_b = d; m_have = 2; end
    else m_over = 1'b1;
  endtask

  task automatic m_handshake();
    if (m_have == 2) begin m_pairs++; m_have = 0; end
  endtask

  task automatic m_clear();
    m_have = 0; m_over = 1'b0; m_pairs = 0;
  endtask

  function automatic logic [26:0] exp_vec();
    logic [7:0] cnt;
    cnt = m_pairs[7:0];
    return {m_a, m_b, (m_have == 2), m_over, (m_have != 0), cnt};
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_strobe(input logic [7:0] d, input int hold);
    @(negedge clk);
    data_in = d;
    strobe_async = 1'b1;
    repeat (hold) @(negedge clk);
    strobe_async = 1'b0;
    repeat (S + 2) @(negedge clk);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_clear(output int pulses);
    @(negedge clk);
    clear_async = 1'b1;
    pulses = 0;
    repeat (S + 6) begin
      @(negedge clk);
      if (acc_clear) pulses++;
    end
    clear_async = 1'b0;
    repeat (S + 2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
    tests++;
    if (acc_clear !== 1'b0) begin
      fails++;
      $display("FAIL reset_acc_clear: got %b expected 0", acc_clear);
    end
  endtask

  task automatic test_load_path();
    drive_strobe(8'h12, S + 3); m_strobe(8'h12);
    drive_strobe(8'h34, S + 3); m_strobe(8'h34);
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL load_pair: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
    pulse_ready(); m_handshake();
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL load_handshake: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
  endtask

  task automatic test_overrun_clear();
    int pulses;
    drive_strobe(8'h9A, S + 3); m_strobe(8'h9A);
    drive_strobe(8'hBC, S + 3); m_strobe(8'hBC);
    drive_strobe(8'h55, S + 3); m_strobe(8'h55);
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL overrun_set: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
    drive_clear(pulses); m_clear();
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL clear_pulse_len: got %0d cycles expected 1", pulses);
    end
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL clear_state: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    drive_strobe(8'h11, S + 3); m_strobe(8'h11);
    drive_strobe(8'h22, S + 3); m_strobe(8'h22);
    // Strobe rises at a falling edge; its event is sampled S+1 rising edges
    // later, which is the same edge that samples op_ready raised below.
    @(negedge clk);
    data_in = 8'hA0;
    strobe_async = 1'b1;
    repeat (S) @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    repeat (2) @(negedge clk);
    strobe_async = 1'b0;
    repeat (S + 2) @(negedge clk);
    m_handshake(); m_strobe(8'hA0);
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL back_to_back: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
  endtask

  task automatic test_edge_enable();
    // Finish the pair left over from the back-to-back case.
    drive_strobe(8'h5C, S + 3); m_strobe(8'h5C);
    pulse_ready(); m_handshake();
    drive_strobe(8'h3D, 10); m_strobe(8'h3D);
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL long_strobe_one_load: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
    @(negedge clk); ena = 1'b0;
    drive_strobe(8'h77, S + 3);
    @(negedge clk); ena = 1'b1;
    repeat (S + 2) @(negedge clk);
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL ena_low_ignored: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
    @(negedge clk);
    ena = 1'b0;
    data_in = 8'h66;
    strobe_async = 1'b1;
    repeat (6) @(negedge clk);
    ena = 1'b1;
    repeat (6) @(negedge clk);
    strobe_async = 1'b0;
    repeat (S + 2) @(negedge clk);
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL ena_rise_no_event: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
  endtask

  task automatic test_random();
    int pulses;
    int r;
    logic [7:0] d;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        d = 8'($urandom);
        drive_strobe(d, $urandom_range(S + 2, S + 6));
        m_strobe(d);
      end else if (r < 9) begin
        pulse_ready();
        m_handshake();
      end else begin
        drive_clear(pulses);
        m_clear();
        tests++;
        if (pulses != 1) begin
          fails++;
          $display("FAIL rand_clear_pulse: step %0d got %0d expected 1", i, pulses);
        end
      end
      tests++;
      if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
        fails++;
        $display("FAIL rand_step_%0d: got %h expected %h", i,
                 {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
      end
    end
  endtask

  task automatic test_wrap_reset();
    int pulses;
    logic [7:0] d;
    drive_clear(pulses); m_clear();
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom); drive_strobe(d, S + 3); m_strobe(d);
      d = 8'($urandom); drive_strobe(d, S + 3); m_strobe(d);
      pulse_ready(); m_handshake();
    end
    tests++;
    if (pair_count !== 8'd0) begin
      fails++;
      $display("FAIL pair_count_wrap: got %0d expected 0", pair_count);
    end
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count} !== exp_vec()) begin
      fails++;
      $display("FAIL wrap_state: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count}, exp_vec());
    end
    drive_strobe(8'hC3, S + 3); m_strobe(8'hC3);
    tests++;
    if (busy !== 1'b1 || op_a !== 8'hC3) begin
      fails++;
      $display("FAIL pre_reset_load_b: got busy=%b op_a=%h expected busy=1 op_a=c3", busy, op_a);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_have = 0; m_a = '0; m_b = '0; m_over = 1'b0; m_pairs = 0;
    tests++;
    if ({op_a, op_b, op_valid, overrun, busy, pair_count, acc_clear} !== {exp_vec(), 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got %h expected %h",
               {op_a, op_b, op_valid, overrun, busy, pair_count, acc_clear}, {exp_vec(), 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_path();
    test_overrun_clear();
    test_back_to_back();
    test_edge_enable();
    test_random();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
